ustc_fan_collect: RTL and testbench

Row-sum collector downstream of the unstructured FAN reduction network. It accepts one 32-lane FAN output beat at a time and serially scans the lanes flagged as final partial sums. Each flagged lane's N_STACK-wide sum is added into a per-row accumulator bank. At tile end the bank drains row by row over a valid/ready output, and each row is cleared as it is read.

---
 rtl/ustc_fan_collect.sv | 160 ++++++++++++++++
 tb/tb_ustc_fan_collect.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ustc_fan_collect.sv
// Row-sum collector behind the FAN reduction network: serially folds emitting lanes
// of one beat into a per-row accumulator bank, then drains and clears the bank at tile end.
module ustc_fan_collect #(
   parameter int NUM_IN  = 32,
   parameter int N_STACK = 4,
   parameter int DW_DATA = 32,
   parameter int DW_ROW  = 4,
   parameter int DW_CTRL = 4,
   parameter int DW_LINE = N_STACK*DW_DATA+DW_ROW+DW_CTRL
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_IN*DW_LINE-1:0]  in,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [N_STACK*DW_DATA-1:0] out_data,
   output logic [DW_ROW-1:0]          out_row,
   output logic                       out_last,
   output logic                       out_valid,
   input  logic                       out_ready
);

   localparam int DW_SUM = N_STACK*DW_DATA;
   localparam int DEPTH  = 1 << DW_ROW;
   localparam int LW     = $clog2(NUM_IN);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

   state_t                   state, next_state;
   logic [DW_SUM+DW_ROW-1:0] lane_p0 [NUM_IN];
   logic [NUM_IN-1:0]        pending;
   logic                     last_flag;
   logic [DW_ROW-1:0]        idx;
   logic [DW_SUM-1:0]        acc [DEPTH];

   logic [NUM_IN-1:0]        in_pend;
   logic                     in_last;
   logic [NUM_IN-1:0]        rsvd_unused;
   logic [LW-1:0]            sel;
   logic                     sel_found;
   logic [NUM_IN-1:0]        sel_mask;
   logic [DW_SUM-1:0]        sel_data;
   logic [DW_ROW-1:0]        sel_row;
   logic                     scan_done;
   logic                     accept;
   logic                     drain_fire;
   logic                     idx_end;

   // Per-element two's-complement add; overflow wraps modulo 2^DW_DATA.
   function automatic logic [DW_SUM-1:0] wrap_add(input logic [DW_SUM-1:0] a,
                                                  input logic [DW_SUM-1:0] b);
      logic [DW_SUM-1:0]         r;
      logic signed [DW_DATA-1:0] ea, eb;
      r = '0;
      for (int s = 0; s < N_STACK; s++) begin
         ea = a[s*DW_DATA +: DW_DATA];
         eb = b[s*DW_DATA +: DW_DATA];
         r[s*DW_DATA +: DW_DATA] = ea + eb;
      end
      return r;
   endfunction

   always_comb begin
      in_pend     = '0;
      in_last     = 1'b0;
      rsvd_unused = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         in_pend[i]     = in[i*DW_LINE+DW_SUM+DW_ROW] & in[i*DW_LINE+DW_SUM+DW_ROW+1];
         in_last        = in_last | (in[i*DW_LINE+DW_SUM+DW_ROW] & in[i*DW_LINE+DW_SUM+DW_ROW+2]);
         rsvd_unused[i] = in[i*DW_LINE+DW_SUM+DW_ROW+3];
      end
   end

   // Lowest pending lane wins: scanning downward leaves the smallest index selected.
   always_comb begin
      sel       = '0;
      sel_found = 1'b0;
      for (int i = NUM_IN-1; i >= 0; i--) begin
         if (pending[i]) begin
            sel       = LW'(i);
            sel_found = 1'b1;
         end
      end
      sel_mask      = '0;
      sel_mask[sel] = sel_found;
   end

   assign sel_data  = lane_p0[sel][DW_SUM-1:0];
   assign sel_row   = lane_p0[sel][DW_SUM +: DW_ROW];
   assign scan_done = ((pending & ~sel_mask) == '0);
   assign idx_end   = (idx == {DW_ROW{1'b1}});

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      accept     = 1'b0;
      drain_fire = 1'b0;
      case (state)
         IDLE: begin
            in_ready = rst;
            accept   = in_valid & rst;
            if (accept) next_state = SCAN;
         end
         SCAN: begin
            if (!sel_found || scan_done) next_state = last_flag ? DRAIN : IDLE;
         end
         DRAIN: begin
            out_valid  = 1'b1;
            drain_fire = out_ready;
            if (out_ready && idx_end) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Lane payloads are plain data and need no reset; a reset discards them via pending.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < NUM_IN; i++) lane_p0[i] <= in[i*DW_LINE +: DW_SUM+DW_ROW];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending   <= '0;
         last_flag <= 1'b0;
         idx       <= '0;
         for (int r = 0; r < DEPTH; r++) acc[r] <= '0;
      end else begin
         if (accept) begin
            pending   <= in_pend;
            last_flag <= in_last;
         end
         if (state == SCAN && sel_found) begin
            acc[sel_row] <= wrap_add(acc[sel_row], sel_data);
            pending[sel] <= 1'b0;
         end
         if (drain_fire) begin
            acc[idx] <= '0;
            if (idx_end) begin
               idx       <= '0;
               last_flag <= 1'b0;
            end else begin
               idx <= idx + 1'b1;
            end
         end
      end
   end

   assign out_data = out_valid ? acc[idx] : '0;
   assign out_row  = out_valid ? idx : '0;
   assign out_last = out_valid & idx_end;

endmodule

// File: tb/tb_ustc_fan_collect.sv
// Directed bench for ustc_fan_collect: a bank model fills an expected-drain queue at
// stimulus time; drain words are popped and compared as the DUT hands them over.
module tb_ustc_fan_collect;

   localparam int NUM_IN  = 32;
   localparam int N_STACK = 4;
   localparam int DW_DATA = 32;
   localparam int DW_ROW  = 4;
   localparam int DW_CTRL = 4;
   localparam int DW_SUM  = N_STACK*DW_DATA;
   localparam int DW_LINE = DW_SUM+DW_ROW+DW_CTRL;
   localparam int DEPTH   = 1 << DW_ROW;
   localparam int BW      = NUM_IN*DW_LINE;

   logic              clk = 1'b0;
   logic              rst;
   logic [BW-1:0]     in;
   logic              in_valid;
   logic              in_ready;
   logic [DW_SUM-1:0] out_data;
   logic [DW_ROW-1:0] out_row;
   logic              out_last;
   logic              out_valid;
   logic              out_ready;

   ustc_fan_collect #(
      .NUM_IN(NUM_IN), .N_STACK(N_STACK), .DW_DATA(DW_DATA),
      .DW_ROW(DW_ROW), .DW_CTRL(DW_CTRL)
   ) dut (
      .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_row(out_row), .out_last(out_last),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW_SUM-1:0] data;
      logic [DW_ROW-1:0] row;
      logic              last;
   } exp_t;

   exp_t              q[$];
   logic [DW_SUM-1:0] mdl [DEPTH];
   logic [BW-1:0]     beat_v;
   int                n_vec = 0;
   int                n_err = 0;

   localparam logic [3:0] C_V   = 4'b0001;
   localparam logic [3:0] C_VE  = 4'b0011;
   localparam logic [3:0] C_VL  = 4'b0101;
   localparam logic [3:0] C_VEL = 4'b0111;
   localparam logic [3:0] C_EL  = 4'b0110;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [DW_SUM-1:0] obs, input logic [DW_SUM-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int r = 0; r < DEPTH; r++) mdl[r] = '0;
   endtask

   task automatic set_lane(input int i, input logic [DW_SUM-1:0] d, input logic [DW_ROW-1:0] row,
                           input logic [DW_CTRL-1:0] ctrl);
      beat_v[i*DW_LINE +: DW_LINE] = {ctrl, row, d};
   endtask

   task automatic send_beat();
      int k = 0;
      int n = 0;
      bit lst = 0;
      logic [DW_CTRL-1:0] c;
      logic [DW_ROW-1:0]  r;
      logic [DW_SUM-1:0]  d;
      while (!in_ready && n < 50) begin tick(); n++; end
      check("ready_before_beat", in_ready, 1);
      for (int i = 0; i < NUM_IN; i++) begin
         d = beat_v[i*DW_LINE +: DW_SUM];
         r = beat_v[i*DW_LINE+DW_SUM +: DW_ROW];
         c = beat_v[i*DW_LINE+DW_SUM+DW_ROW +: DW_CTRL];
         if (c[0] && c[1]) begin
            k++;
            for (int s = 0; s < N_STACK; s++)
               mdl[r][s*DW_DATA +: DW_DATA] = mdl[r][s*DW_DATA +: DW_DATA] + d[s*DW_DATA +: DW_DATA];
         end
         if (c[0] && c[2]) lst = 1;
      end
      in = beat_v;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("ready_low_in_scan", in_ready, 0);
      n = 0;
      while (!(in_ready || out_valid) && n < 100) begin tick(); n++; end
      check("scan_cycles", n, (k > 0) ? k : 1);
      check("drain_after_scan", out_valid, lst);
      if (lst) begin
         for (int row = 0; row < DEPTH; row++) begin
            exp_t e;
            e.data = mdl[row];
            e.row  = DW_ROW'(row);
            e.last = (row == DEPTH-1);
            q.push_back(e);
         end
         clear_model();
      end
   endtask

   task automatic drain(input bit toggle);
      int cyc = 0;
      while (q.size() > 0 && cyc < 200) begin
         out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
         check("drain_valid", out_valid, 1);
         if (out_valid) begin
            check("drain_data", out_data, q[0].data);
            check("drain_row", out_row, q[0].row);
            check("drain_last", out_last, q[0].last);
            if (out_ready) void'(q.pop_front());
         end else begin
            cyc = 200;
         end
         tick();
         cyc++;
      end
      check("drain_complete", q.size(), 0);
      q.delete();
      out_ready = 1'b0;
      check("valid_after_drain", out_valid, 0);
      check("ready_after_drain", in_ready, 1);
   endtask

   task automatic last_only_drain(input bit toggle);
      beat_v = '0;
      set_lane(12, 128'hDEAD, 4'd6, C_VL);
      send_beat();
      drain(toggle);
   endtask

   initial begin
      rst = 1'b0;
      in = '0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      clear_model();
      #3;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_row", out_row, 0);
      check("rst_out_data", out_data, 0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("ready_after_rst", in_ready, 1);

      // Single emitting lane, drained with out_last on row 15.
      beat_v = '0;
      set_lane(5, {32'd4, 32'd3, 32'd2, 32'd1}, 4'd3, C_VEL);
      send_beat();
      drain(1'b0);

      // Three lanes collide on row 9.
      beat_v = '0;
      set_lane(0, 128'd10, 4'd9, C_VEL);
      set_lane(7, 128'd20, 4'd9, C_VE);
      set_lane(31, 128'd30, 4'd9, C_VE);
      send_beat();
      drain(1'b0);

      // Element wrap across two beats; the bank persists across the non-last beat.
      beat_v = '0;
      set_lane(0, {96'd0, 32'hFFFF_FFFF}, 4'd0, C_VE);
      send_beat();
      beat_v = '0;
      set_lane(0, {32'h8000_0000, 32'h7FFF_FFFF, 32'd5, 32'd2}, 4'd0, C_VEL);
      send_beat();
      drain(1'b0);

      // Backpressure: several rows, drain with out_ready toggling, then re-drain zeros.
      beat_v = '0;
      set_lane(1, {32'd11, 32'd12, 32'd13, 32'd14}, 4'd1, C_VE);
      set_lane(2, {32'hFFFF_FFF0, 32'd0, 32'd7, 32'd8}, 4'd15, C_VE);
      set_lane(3, {32'd100, 32'd200, 32'd300, 32'd400}, 4'd8, C_VE);
      set_lane(4, 128'd77, 4'd2, C_VL);
      send_beat();
      drain(1'b1);
      last_only_drain(1'b1);

      // Ignore rules: invalid lane with emit+last, then a valid non-emitting lane.
      beat_v = '0;
      set_lane(9, 128'd55, 4'd4, C_EL);
      send_beat();
      beat_v = '0;
      set_lane(10, 128'd66, 4'd5, C_V);
      set_lane(11, 128'd3, 4'd5, C_VE);
      send_beat();
      last_only_drain(1'b0);

      // Full-emit beat: all 32 lanes, two per row.
      beat_v = '0;
      for (int i = 0; i < NUM_IN; i++)
         set_lane(i, {32'(i*3), 32'(i*2), 32'(i+1), 32'(1000-i)}, 4'(i % DEPTH), (i == 31) ? C_VEL : C_VE);
      send_beat();
      drain(1'b1);

      // Reset mid-scan discards the beat and all sums; no drain follows.
      beat_v = '0;
      set_lane(0, 128'd1, 4'd1, C_VE);
      send_beat();
      beat_v = '0;
      for (int i = 0; i < NUM_IN; i++) set_lane(i, 128'd9, 4'(i % DEPTH), C_VEL);
      in = beat_v;
      in_valid = 1'b1;
      tick();
      tick();
      tick();
      #2;
      rst = 1'b0;
      #1;
      check("midscan_rst_ready", in_ready, 0);
      check("midscan_rst_valid", out_valid, 0);
      tick();
      in_valid = 1'b0;
      rst = 1'b1;
      clear_model();
      for (int c = 0; c < 40; c++) begin
         check("post_rst_no_drain", out_valid, 0);
         tick();
      end
      last_only_drain(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
